// File: rtl/a2s_rx_pkg.sv
// Shared types for the A2S receive controller.
// Holds the controller state encoding and FIFO level sizing.
package a2s_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LVL_W_DEF = lvl_w(4);

endpackage

// File: rtl/sync_fifo.sv
// Registered single-clock FIFO with occupancy count.
// Head word is read combinationally from the storage array.
module sync_fifo
  import a2s_rx_pkg::*;
#(
  parameter  int DW    = 64,
  parameter  int DEPTH = 4,
  localparam int LW    = lvl_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == LW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_q];
  assign level   = cnt_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q + PW'(do_push);
    rd_d  = rd_q + PW'(do_pop);
    cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/a2s_rx_ctrl.sv
// Clocked receive side of the A2S channel: Si/So handshake,
// FIFO capture, valid/ready output and received-word count.
module a2s_rx_ctrl
  import a2s_rx_pkg::*;
#(
  parameter  int DW    = 64,
  parameter  int DEPTH = 4,
  parameter  int CW    = 32,
  localparam int LW    = lvl_w(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          Si,
  output logic          So,
  input  logic [DW-1:0] Din,
  input  logic          en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] rx_count,
  output logic [LW-1:0] level,
  output logic          stall
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_q, stall_d;
  logic          push, full, empty;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (push),
    .pop   (out_ready),
    .din   (Din),
    .dout  (out_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Full is judged on the registered level, so a same-cycle pop never
  // frees room for a push.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Si && en) begin
          if (!full) begin
            push    = 1'b1;
            cnt_d   = cnt_q + CW'(1);
            state_d = HOLD;
          end else begin
            stall_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!Si) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign So        = (state_q == HOLD);
  assign out_valid = ~empty;
  assign rx_count  = cnt_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_a2s_rx_ctrl.sv
// Directed bench for a2s_rx_ctrl with immediate-assertion checks.
// Final phase streams tokens against a queue scoreboard.
module tb_a2s_rx_ctrl;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          Si;
  logic          So;
  logic [DW-1:0] Din;
  logic          en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] rx_count;
  logic [LW-1:0] level;
  logic          stall;

  int nvec = 0;
  int nerr = 0;
  int exp_cnt;

  a2s_rx_ctrl #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .Si        (Si),
    .So        (So),
    .Din       (Din),
    .en        (en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .rx_count  (rx_count),
    .level     (level),
    .stall     (stall)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hs(input logic [DW-1:0] d);
    Si  = 1'b1;
    Din = d;
    step();
    chk("hs_so_hi", 64'(So), 64'd1);
    Si = 1'b0;
    step();
    chk("hs_so_lo", 64'(So), 64'd0);
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] tok;
  int sent;
  int got;

  initial begin
    RESET     = 1'b0;
    Si        = 1'b0;
    Din       = '0;
    en        = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_so", 64'(So), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_count", 64'(rx_count), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    RESET = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_so", 64'(So), 64'd0);
      chk("idle_valid", 64'(out_valid), 64'd0);
      chk("idle_level", 64'(level), 64'd0);
      chk("idle_count", 64'(rx_count), 64'd0);
    end

    // Single token
    out_ready = 1'b1;
    Si  = 1'b1;
    Din = 64'h0123_4567_89AB_CDEF;
    step();
    chk("one_so_k", 64'(So), 64'd1);
    chk("one_valid", 64'(out_valid), 64'd1);
    chk("one_data", out_data, 64'h0123_4567_89AB_CDEF);
    chk("one_count", 64'(rx_count), 64'd1);
    step();
    chk("one_so_k1", 64'(So), 64'd1);
    chk("one_popped", 64'(out_valid), 64'd0);
    step();
    chk("one_so_k2", 64'(So), 64'd1);
    Si = 1'b0;
    step();
    chk("one_so_k3", 64'(So), 64'd0);
    chk("one_count2", 64'(rx_count), 64'd1);
    exp_cnt = 1;

    // Back-pressure
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) hs(64'(i));
    exp_cnt += 4;
    chk("bp_level4", 64'(level), 64'd4);
    chk("bp_head", out_data, 64'd1);
    Si  = 1'b1;
    Din = 64'd5;
    step();
    chk("bp_so_held", 64'(So), 64'd0);
    chk("bp_stall", 64'(stall), 64'd1);
    step();
    chk("bp_stable", out_data, 64'd1);
    chk("bp_stall2", 64'(stall), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_no_push", 64'(So), 64'd0);
    chk("bp_level3", 64'(level), 64'd3);
    chk("bp_head2", out_data, 64'd2);
    step();
    exp_cnt += 1;
    chk("bp_so5", 64'(So), 64'd1);
    chk("bp_level4b", 64'(level), 64'd4);
    chk("bp_stall0", 64'(stall), 64'd0);
    chk("bp_count", 64'(rx_count), 64'(exp_cnt));
    Si = 1'b0;
    step();
    chk("bp_so5_lo", 64'(So), 64'd0);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_data", out_data, 64'(i));
      step();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_level", 64'(level), 64'd0);

    // en control
    en  = 1'b0;
    Si  = 1'b1;
    Din = 64'hAA;
    step();
    step();
    chk("en0_so", 64'(So), 64'd0);
    chk("en0_stall", 64'(stall), 64'd0);
    chk("en0_count", 64'(rx_count), 64'(exp_cnt));
    en = 1'b1;
    step();
    exp_cnt += 1;
    chk("en1_so", 64'(So), 64'd1);
    chk("en1_data", out_data, 64'hAA);
    chk("en1_count", 64'(rx_count), 64'(exp_cnt));
    en = 1'b0;
    step();
    chk("en_hold_so", 64'(So), 64'd1);
    Si = 1'b0;
    step();
    chk("en_hold_done", 64'(So), 64'd0);
    en = 1'b1;

    // Reset mid-HOLD
    out_ready = 1'b0;
    hs(64'h11);
    Si  = 1'b1;
    Din = 64'h22;
    step();
    chk("rh_so", 64'(So), 64'd1);
    chk("rh_level", 64'(level), 64'd2);
    RESET = 1'b0;
    step();
    chk("rh_so0", 64'(So), 64'd0);
    chk("rh_level0", 64'(level), 64'd0);
    chk("rh_valid0", 64'(out_valid), 64'd0);
    chk("rh_count0", 64'(rx_count), 64'd0);
    RESET = 1'b1;
    Si    = 1'b0;
    step();
    Si  = 1'b1;
    Din = 64'h33;
    step();
    exp_cnt = 1;
    chk("rh_fresh_so", 64'(So), 64'd1);
    chk("rh_fresh_data", out_data, 64'h33);
    chk("rh_fresh_count", 64'(rx_count), 64'(exp_cnt));
    Si = 1'b0;
    step();
    chk("rh_fresh_lo", 64'(So), 64'd0);
    out_ready = 1'b1;
    step();
    chk("rh_drained", 64'(level), 64'd0);

    // Random stream against a queue scoreboard
    sent = 0;
    got  = 0;
    for (int c = 0; c < 600 && got < 16; c++) begin
      if (Si && So) begin
        Si = 1'b0;
      end else if (!Si && !So && sent < 16) begin
        tok = {$urandom, $urandom};
        q.push_back(tok);
        Si  = 1'b1;
        Din = tok;
        sent++;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream_extra", 64'(out_valid), 64'd0);
        end else begin
          chk("stream_data", out_data, q.pop_front());
        end
        got++;
      end
      step();
    end
    chk("stream_got", 64'(got), 64'd16);
    chk("stream_count", 64'(rx_count), 64'(exp_cnt + 16));
    chk("stream_level", 64'(level), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
